lea_key_schedule: RTL and testbench
===================================

// Module: lea_key_schedule
// PURPOSE
//  Sequential, parametrised LEA key schedule for 128/192/256-bit keys. Latches a key on start and emits
//  one 192-bit round key per accepted valid/ready beat (24/28/32 rounds). Holds the T-word state in
//  registers and applies delta[i] rotate-add-rotate per round; feeds the round-function datapath.
// PARAMETERS
//  MAX_KEY_BITS  256  largest supported key (128|192|256); key_len above it -> err, no run
//  RK_W          192  round-key width (6x32); fixed, exposed for downstream width checks
// PORTS
//  clk       in   1    clock; all state updates on posedge
//  rst_n     in   1    asynchronous, active-low reset
//  start     in   1    request; accepted only when busy=0
//  key_len   in   2    00=128, 01=192, 10=256, 11=illegal; sampled with start
//  key       in   256  key; word j = key[32j+31:32j]; unused upper words ignored
//  abort     in   1    synchronous cancel of a run in progress
//  busy      out  1    high from accepted start until last round key accepted or abort
//  rk_valid  out  1    round key on rk is valid
//  rk_ready  in   1    consumer accepts rk this cycle when rk_valid=1
//  rk        out  192  round key {RK5..RK0}, RK0 in [31:0]
//  rk_round  out  5    round index of rk (0..Nr-1)
//  rk_last   out  1    high with rk_valid on round Nr-1
//  err       out  1    sticky; set on start with illegal/unsupported key_len, cleared by next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, any time, incl. mid-run): busy=0, rk_valid=0, rk=0, rk_round=0, rk_last=0, err=0,
//   FSM=IDLE, T regs=0; no partial output survives.
//  Constants: d0..d7 = c3efe9db 44626b02 79e27c8a 78df30ec 715ea49e c785da0a e04ef22a e5c40957.
//  Nr: 24 (128), 28 (192), 32 (256). Rotation amounts r = {1,3,6,11,13,17}. All adds mod 2^32.
//  128: T[j] <= ROL_r[j](T[j] + ROL_(i+j)(d[i%4])), j=0..3; RK = {T1,T3,T1,T2,T1,T0}.
//  192: T[j] <= ROL_r[j](T[j] + ROL_(i+j)(d[i%6])), j=0..5; RK = {T5..T0}.
//  256: k=(6i+j)%8: T[k] <= ROL_r[j](T[k] + ROL_(i+j)(d[i%8])), j=0..5; RK = {T[(6i+5)%8]..T[(6i)%8]}.
//  Rotate amounts taken mod 32 (i+j up to 36).
//  FSM: IDLE -> LOAD on start with legal key_len (T <= key words, round=0, err<=0, busy<=1);
//   illegal key_len: err<=1, stay IDLE, busy stays 0.
//   LOAD -> RUN after one cycle: rk for round 0 registered, rk_valid=1 (start edge E0, rk_valid high after E1).
//   RUN: output register advances when (!rk_valid | rk_ready); rk/rk_round/rk_last stable while
//   rk_valid & !rk_ready. With rk_ready held high, one round key per cycle.
//   Accept of rk_last -> IDLE at that edge: rk_valid<=0, busy<=0. start in the same cycle is ignored
//   (busy still 1); next start accepted the following cycle.
//  start while busy=1: ignored, no effect on state or err.
//  abort (busy=1): next edge rk_valid<=0, busy<=0, FSM=IDLE, err unchanged; abort wins over rk_ready.
//   abort while IDLE: no effect.
//  key/key_len changes after acceptance have no effect on the running schedule.
//  rk_round counts 0..Nr-1 only; never wraps within a run.
// TESTING
//  key=0, key_len=00, rk_ready=1: RK0 word0=87dfd3b7, word1=3efe9dbc; 24 beats, rk_last on round 23.
//  KAT 128/192/256 vs software model, all rounds bit-exact; round counts 24/28/32 exactly.
//  rk_ready random (~50%): rk/rk_round stable while stalled, no beats lost or duplicated.
//  key_len=11 or 10 with MAX_KEY_BITS=128: err=1, busy=0, no rk_valid; next legal start clears err.
//  abort at round 10 then immediate start: old run gone, new run starts at round 0 with new key.
//  rst_n low mid-run (asynchronously, between edges): all outputs 0 immediately; start after release runs clean.

Source files
------------

// File: rtl/lea_key_schedule.sv
// lea_key_schedule
//   Sequential LEA key schedule for 128/192/256-bit keys. A key is latched on
//   an accepted start; one 192-bit round key is then produced per accepted
//   valid/ready beat (24/28/32 rounds). The T-word state is kept in registers
//   and advanced by one delta rotate-add-rotate step per round.
//
// Ports
//   clk       clock, all state updates on posedge
//   rst_n     asynchronous active-low reset
//   start     run request, accepted only while busy=0
//   key_len   00=128, 01=192, 10=256, 11=illegal (sampled with start)
//   key       key words, word j = key[32j+31:32j]
//   abort     synchronous cancel of a run in progress
//   busy      high from accepted start until last round key accepted or abort
//   rk_valid  round key on rk is valid
//   rk_ready  consumer accepts rk this cycle when rk_valid=1
//   rk        round key {RK5..RK0}, RK0 in [31:0]
//   rk_round  round index of rk (0..Nr-1)
//   rk_last   high with rk_valid on the final round
//   err       sticky illegal/unsupported key_len flag, cleared by next accepted start
//
// FSM states
//   IDLE | waiting for start
//   LOAD | key words in T, computing round 0
//   RUN  | round key presented, advancing on each accepted beat

module lea_key_schedule #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_W         = 192
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      key_len,
    input  logic [255:0]    key,
    input  logic            abort,
    output logic            busy,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic [RK_W-1:0] rk,
    output logic [4:0]      rk_round,
    output logic            rk_last,
    output logic            err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t      state, state_next;
    logic [31:0] t_q   [8];
    logic [31:0] t_new [8];
    logic [1:0]  mode;
    logic [4:0]  rnd;        // index of the next round to compute
    logic [4:0]  last_rnd;
    logic [191:0] rk_new;
    logic [31:0] d;
    logic [4:0]  prod;
    logic [2:0]  base;
    logic [2:0]  k;
    logic        key_ok;
    logic        do_load, do_step, do_err, do_clr;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] tmp;
        tmp = {x, x} << s;
        return tmp[63:32];
    endfunction

    function automatic logic [31:0] delta(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'hc3efe9db;
            3'd1:    return 32'h44626b02;
            3'd2:    return 32'h79e27c8a;
            3'd3:    return 32'h78df30ec;
            3'd4:    return 32'h715ea49e;
            3'd5:    return 32'hc785da0a;
            3'd6:    return 32'he04ef22a;
            default: return 32'he5c40957;
        endcase
    endfunction

    function automatic logic [4:0] rot_amt(input int j);
        case (j)
            0:       return 5'd1;
            1:       return 5'd3;
            2:       return 5'd6;
            3:       return 5'd11;
            4:       return 5'd13;
            default: return 5'd17;
        endcase
    endfunction

    always_comb begin
        key_ok = 1'b0;
        case (key_len)
            2'b00:   key_ok = 1'b1;
            2'b01:   key_ok = (MAX_KEY_BITS >= 192);
            2'b10:   key_ok = (MAX_KEY_BITS >= 256);
            default: key_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (mode)
            2'b00:   last_rnd = 5'd23;
            2'b01:   last_rnd = 5'd27;
            default: last_rnd = 5'd31;
        endcase
    end

    // One schedule round computed from the current T words and round index.
    // In 256-bit mode the six touched words slide around the eight-word ring.
    always_comb begin
        prod = rnd * 5'd6;
        base = prod[2:0];
        case (mode)
            2'b00:   d = delta({1'b0, rnd[1:0]});
            2'b01:   d = delta(3'(rnd % 5'd6));
            default: d = delta(rnd[2:0]);
        endcase
        t_new  = t_q;
        k      = '0;
        rk_new = '0;
        for (int j = 0; j < 6; j++) begin
            if (mode != 2'b00 || j < 4) begin
                k = (mode == 2'b10) ? base + 3'(j) : 3'(j);
                t_new[k] = rol32(t_q[k] + rol32(d, rnd + 5'(j)), rot_amt(j));
            end
        end
        case (mode)
            2'b00:   rk_new = {t_new[1], t_new[3], t_new[1], t_new[2], t_new[1], t_new[0]};
            2'b01:   rk_new = {t_new[5], t_new[4], t_new[3], t_new[2], t_new[1], t_new[0]};
            default: begin
                for (int j = 0; j < 6; j++)
                    rk_new[32*j +: 32] = t_new[3'(base + 3'(j))];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_step    = 1'b0;
        do_err     = 1'b0;
        do_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (key_ok) begin
                        do_load    = 1'b1;
                        state_next = LOAD;
                    end else begin
                        do_err = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    do_clr     = 1'b1;
                    state_next = IDLE;
                end else begin
                    do_step    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    do_clr     = 1'b1;
                    state_next = IDLE;
                end else if (!rk_valid || rk_ready) begin
                    if (rk_valid && rk_last) begin
                        do_clr     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        do_step = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 8; j++) t_q[j] <= '0;
            mode     <= '0;
            rnd      <= '0;
            rk       <= '0;
            rk_round <= '0;
            rk_last  <= 1'b0;
            rk_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (do_load) begin
                for (int j = 0; j < 8; j++) t_q[j] <= key[32*j +: 32];
                mode <= key_len;
                rnd  <= '0;
                err  <= 1'b0;
            end
            if (do_err) err <= 1'b1;
            if (do_step) begin
                t_q      <= t_new;
                rk       <= rk_new;
                rk_round <= rnd;
                rk_last  <= (rnd == last_rnd);
                rk_valid <= 1'b1;
                rnd      <= rnd + 5'd1;
            end
            if (do_clr) begin
                rk_valid <= 1'b0;
                rk_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lea_key_schedule.sv
module tb_lea_key_schedule;

    typedef struct {
        logic [191:0] rk;
        logic [4:0]   rnd;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key = '0;
    logic         abort = 1'b0;
    logic         busy, rk_valid, rk_last, err;
    logic         rk_ready = 1'b1;
    logic [191:0] rk;
    logic [4:0]   rk_round;

    logic         start2 = 1'b0;
    logic [1:0]   key_len2 = 2'b00;
    logic         busy2, rk_valid2, rk_last2, err2;
    logic [191:0] rk2;
    logic [4:0]   rk_round2;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   beats = 0;

    logic [31:0] dc [8] = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
                           32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957};
    int rr [6] = '{1, 3, 6, 11, 13, 17};

    always #5 clk = ~clk;

    lea_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
        .abort(abort), .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk(rk), .rk_round(rk_round), .rk_last(rk_last), .err(err)
    );

    lea_key_schedule #(.MAX_KEY_BITS(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .start(start2), .key_len(key_len2), .key(key),
        .abort(1'b0), .busy(busy2), .rk_valid(rk_valid2), .rk_ready(1'b1),
        .rk(rk2), .rk_round(rk_round2), .rk_last(rk_last2), .err(err2)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int s);
        int m;
        m = s % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    // Reference schedule written directly from the round equations.
    task automatic push_model(input logic [255:0] kin, input logic [1:0] len);
        logic [31:0] t [8];
        int   nr, k;
        exp_t e;
        for (int j = 0; j < 8; j++) t[j] = kin[32*j +: 32];
        nr = (len == 2'b00) ? 24 : (len == 2'b01) ? 28 : 32;
        for (int i = 0; i < nr; i++) begin
            if (len == 2'b00) begin
                for (int j = 0; j < 4; j++) t[j] = rol(t[j] + rol(dc[i % 4], i + j), rr[j]);
                e.rk = {t[1], t[3], t[1], t[2], t[1], t[0]};
            end else if (len == 2'b01) begin
                for (int j = 0; j < 6; j++) t[j] = rol(t[j] + rol(dc[i % 6], i + j), rr[j]);
                e.rk = {t[5], t[4], t[3], t[2], t[1], t[0]};
            end else begin
                for (int j = 0; j < 6; j++) begin
                    k = (6 * i + j) % 8;
                    t[k] = rol(t[k] + rol(dc[i % 8], i + j), rr[j]);
                end
                for (int j = 0; j < 6; j++) e.rk[32*j +: 32] = t[(6 * i + j) % 8];
            end
            e.rnd  = 5'(i);
            e.last = (i == nr - 1);
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rk_valid) begin
            if (q.size() == 0) begin
                check("rk_spurious", 192'(rk_valid), 192'd0);
            end else begin
                check("rk", rk, q[0].rk);
                check("rk_round", 192'(rk_round), 192'(q[0].rnd));
                check("rk_last", 192'(rk_last), 192'(q[0].last));
                if (rk_ready) begin
                    void'(q.pop_front());
                    beats++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [255:0] kin, input logic [1:0] len);
        key = kin;
        key_len = len;
        start = 1'b1;
        push_model(kin, len);
        beats = 0;
        cyc();
        start = 1'b0;
        key = {8{$urandom()}};
        key_len = $urandom_range(0, 3);
    endtask

    task automatic wait_done(input bit rand_ready, input int nr);
        for (int c = 0; c < 400 && (busy || q.size() != 0); c++) begin
            rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
        end
        rk_ready = 1'b1;
        check("run_done", {190'd0, busy, q.size() != 0}, 192'd0);
        check("beat_count", 192'(beats), 192'(nr));
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 192'(busy), 192'd0);
        check("rst_valid", 192'(rk_valid), 192'd0);
        check("rst_rk", rk, 192'd0);
        check("rst_err", 192'(err), 192'd0);
        rst_n = 1'b1;
        cyc();

        // zero key, 128-bit, with start-to-valid latency
        key = '0; key_len = 2'b00; start = 1'b1;
        push_model('0, 2'b00);
        beats = 0;
        cyc();
        start = 1'b0;
        check("lat_busy_e0", 192'(busy), 192'd1);
        check("lat_valid_e0", 192'(rk_valid), 192'd0);
        cyc();
        check("lat_valid_e1", 192'(rk_valid), 192'd1);
        check("zero_w0", 192'(rk[31:0]), 192'h87dfd3b7);
        check("zero_w1", 192'(rk[63:32]), 192'h3efe9dbc);
        wait_done(0, 24);

        start_run(rand_key(), 2'b00); wait_done(0, 24);
        start_run(rand_key(), 2'b01); wait_done(0, 28);
        start_run(rand_key(), 2'b10); wait_done(0, 32);
        start_run(rand_key(), 2'b10); wait_done(1, 32);

        // start while busy must be ignored
        start_run(rand_key(), 2'b01);
        repeat (4) cyc();
        key = rand_key(); key_len = 2'b10; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(1, 28);

        // illegal key length
        key_len = 2'b11; start = 1'b1;
        cyc();
        start = 1'b0;
        check("err_set", 192'(err), 192'd1);
        check("err_busy", 192'(busy), 192'd0);
        cyc();
        check("err_no_valid", 192'(rk_valid), 192'd0);
        start_run(rand_key(), 2'b00);
        check("err_cleared", 192'(err), 192'd0);
        wait_done(0, 24);

        // 256-bit key on a 128-bit-only instance
        key_len2 = 2'b10; start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        check("max_err", 192'(err2), 192'd1);
        check("max_busy", 192'(busy2), 192'd0);
        check("max_valid", 192'(rk_valid2), 192'd0);
        key_len2 = 2'b00; start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        check("max_err_clr", 192'(err2), 192'd0);
        check("max_busy_run", 192'(busy2), 192'd1);

        // abort at round 10, then immediate new start
        start_run(rand_key(), 2'b10);
        for (int c = 0; c < 50 && !(rk_valid && rk_round == 5'd10); c++) cyc();
        check("abort_reach10", 192'(rk_round), 192'd10);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        q.delete();
        check("abort_busy", 192'(busy), 192'd0);
        check("abort_valid", 192'(rk_valid), 192'd0);
        start_run(rand_key(), 2'b01);
        wait_done(0, 28);

        // asynchronous reset mid-run
        start_run(rand_key(), 2'b00);
        repeat (6) cyc();
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check("arst_busy", 192'(busy), 192'd0);
        check("arst_valid", 192'(rk_valid), 192'd0);
        check("arst_rk", rk, 192'd0);
        check("arst_round", 192'(rk_round), 192'd0);
        check("arst_last", 192'(rk_last), 192'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        start_run(rand_key(), 2'b10);
        wait_done(1, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
